icache: RTL and testbench

Direct-mapped, read-only instruction cache between the PC/fetch stage and external instruction memory. It serves the PC's instruction-bus request (enable and address) with same-cycle data on a hit. On a miss it raises a stall request to the pipeline controller and refills one full line from memory with a per-beat valid handshake. It also supports a whole-cache invalidate for self-modifying code and boot.

---
 rtl/icache.sv | 116 +++++++++++
 tb/tb_icache.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with a combinational hit path
// and a single-line refill engine driven by a per-beat memory handshake.
module icache #(
    parameter int LINES      = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic [31:0] cpu_addr,
    output logic [31:0] cpu_data,
    output logic        stallreq,
    input  logic        inv,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid
);
    localparam int OFS  = $clog2(LINE_WORDS);
    localparam int IDX  = $clog2(LINES);
    localparam int TAGW = 30 - OFS - IDX;

    typedef enum logic {S_IDLE, S_REFILL} state_t;

    state_t            r_state;
    logic [OFS-1:0]    r_beat;
    logic [31:0]       r_base;
    logic              r_inv_pend;
    logic [LINES-1:0]  r_valid;
    logic [TAGW-1:0]   r_tag  [LINES];
    logic [31:0]       r_data [LINES][LINE_WORDS];

    logic [IDX-1:0]    w_idx;
    logic [OFS-1:0]    w_ofs;
    logic [TAGW-1:0]   w_tag;
    logic [IDX-1:0]    w_ridx;
    logic [TAGW-1:0]   w_rtag;
    logic              w_hit;
    logic              w_last;

    assign w_idx  = cpu_addr[OFS+2 +: IDX];
    assign w_ofs  = cpu_addr[2 +: OFS];
    assign w_tag  = cpu_addr[31 -: TAGW];
    assign w_ridx = r_base[OFS+2 +: IDX];
    assign w_rtag = r_base[31 -: TAGW];
    assign w_hit  = cpu_en & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_last = (r_beat == OFS'(LINE_WORDS - 1));

    always_comb begin
        cpu_data = '0;
        stallreq = 1'b0;
        mem_req  = 1'b0;
        mem_addr = '0;
        if (!rst) begin
            if (r_state == S_REFILL) begin
                stallreq = 1'b1;
                mem_req  = 1'b1;
                mem_addr = r_base + 32'({r_beat, 2'b00});
            end else if (w_hit) begin
                cpu_data = r_data[w_idx][w_ofs];
            end else begin
                stallreq = cpu_en;
            end
        end
    end

    // Arrays carry no reset; writes are suppressed while rst is high so an
    // abandoned refill never reaches storage.
    always_ff @(posedge clk) begin
        if (!rst && r_state == S_REFILL && mem_valid) begin
            r_data[w_ridx][r_beat] <= mem_rdata;
            if (w_last)
                r_tag[w_ridx] <= w_rtag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_beat     <= '0;
            r_base     <= '0;
            r_inv_pend <= 1'b0;
            r_valid    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (inv)
                        r_valid <= '0;
                    if (cpu_en && !w_hit) begin
                        r_base  <= {cpu_addr[31:OFS+2], {(OFS+2){1'b0}}};
                        r_beat  <= '0;
                        r_state <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (inv) begin
                        r_valid    <= '0;
                        r_inv_pend <= 1'b1;
                    end
                    if (mem_valid) begin
                        r_beat <= r_beat + OFS'(1);
                        if (w_last) begin
                            // An invalidate on the last beat still wins.
                            if (!inv && !r_inv_pend)
                                r_valid[w_ridx] <= 1'b1;
                            r_inv_pend <= 1'b0;
                            r_beat     <= '0;
                            r_state    <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, line hits, conflict eviction,
// invalidate during refill, reset mid-refill and disabled fetch.
module tb_icache;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_en;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_data;
    logic        stallreq;
    logic        inv;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_valid;

    int n_pass  = 0;
    int n_total = 0;
    int stalls;

    icache #(.LINES(64), .LINE_WORDS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_en    (cpu_en),
        .cpu_addr  (cpu_addr),
        .cpu_data  (cpu_data),
        .stallreq  (stallreq),
        .inv       (inv),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Present a missing address in IDLE; the stall must rise that cycle.
    task automatic miss(input logic [31:0] addr);
        cpu_addr = addr;
        #1;
        chk("miss_stall", {31'd0, stallreq}, 32'd1);
        chk("miss_memreq", {31'd0, mem_req}, 32'd0);
        stalls = {31'd0, stallreq};
        tick();
    endtask

    task automatic hit(input logic [31:0] addr, input logic [31:0] exp);
        cpu_addr = addr;
        #1;
        chk("hit_data", cpu_data, exp);
        chk("hit_stall", {31'd0, stallreq}, 32'd0);
        chk("hit_memreq", {31'd0, mem_req}, 32'd0);
        tick();
    endtask

    // Serve nbeats beats of data d0+b, each preceded by gap idle cycles.
    task automatic refill(input logic [31:0] base, input logic [31:0] d0,
                          input int gap, input int inv_beat, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            for (int g = 0; g < gap; g++) begin
                mem_valid = 1'b0;
                inv = 1'b0;
                #1;
                chk("refill_memreq", {31'd0, mem_req}, 32'd1);
                chk("refill_addr", mem_addr, base + 32'(4 * b));
                stalls += int'(stallreq);
                tick();
            end
            mem_valid = 1'b1;
            mem_rdata = d0 + 32'(b);
            inv = (b == inv_beat);
            #1;
            chk("refill_memreq", {31'd0, mem_req}, 32'd1);
            chk("refill_addr", mem_addr, base + 32'(4 * b));
            stalls += int'(stallreq);
            tick();
        end
        mem_valid = 1'b0;
        inv = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cpu_en = 1'b1; cpu_addr = '0; inv = 1'b0;
        mem_valid = 1'b0; mem_rdata = '0;
        tick();
        tick();
        #1;
        chk("rst_stall", {31'd0, stallreq}, 32'd0);
        chk("rst_memreq", {31'd0, mem_req}, 32'd0);
        chk("rst_memaddr", mem_addr, 32'd0);
        chk("rst_data", cpu_data, 32'd0);
        tick();
        rst = 1'b0;

        // Cold miss with one idle cycle before every beat.
        miss(32'h0);
        refill(32'h0, 32'hA0, 1, -1, 4);
        chk("cold_stall_cycles", 32'(stalls), 32'd9);
        hit(32'h0, 32'hA0);
        hit(32'h4, 32'hA1);
        hit(32'h8, 32'hA2);
        hit(32'hC, 32'hA3);

        // Conflict eviction at index 0.
        miss(32'h400);
        refill(32'h400, 32'hB0, 0, -1, 4);
        chk("conflict_stall_cycles", 32'(stalls), 32'd5);
        hit(32'h404, 32'hB1);
        miss(32'h0);
        refill(32'h0, 32'hA0, 0, -1, 4);
        hit(32'hC, 32'hA3);

        // Invalidate during beat 2 of a 0x20 refill.
        miss(32'h20);
        refill(32'h20, 32'hC0, 0, 2, 4);
        miss(32'h20);
        refill(32'h20, 32'hC0, 0, -1, 4);
        hit(32'h28, 32'hC2);

        // Reset after beat 1 of a 0x40 refill.
        miss(32'h40);
        refill(32'h40, 32'hD0, 0, -1, 2);
        rst = 1'b1;
        #1;
        chk("midrst_memreq", {31'd0, mem_req}, 32'd0);
        chk("midrst_stall", {31'd0, stallreq}, 32'd0);
        chk("midrst_data", cpu_data, 32'd0);
        tick();
        #1;
        chk("midrst_memreq2", {31'd0, mem_req}, 32'd0);
        chk("midrst_stall2", {31'd0, stallreq}, 32'd0);
        tick();
        rst = 1'b0;

        // Disabled fetch with stray beats in IDLE.
        cpu_en = 1'b0;
        cpu_addr = 32'h44;
        mem_valid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("dis_data", cpu_data, 32'd0);
            chk("dis_stall", {31'd0, stallreq}, 32'd0);
            chk("dis_memreq", {31'd0, mem_req}, 32'd0);
            tick();
        end
        mem_valid = 1'b0;
        cpu_en = 1'b1;

        miss(32'h40);
        refill(32'h40, 32'hD0, 0, -1, 4);
        chk("postrst_stall_cycles", 32'(stalls), 32'd5);
        hit(32'h44, 32'hD1);
        hit(32'h4C, 32'hD3);

        cpu_en = 1'b0;
        cpu_addr = 32'h4C;
        #1;
        chk("dis_hitline_data", cpu_data, 32'd0);
        chk("dis_hitline_stall", {31'd0, stallreq}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
